rv_muldiv_unit: RTL
===================

// Module: rv_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit; the multi-cycle counterpart of the combinational ALU (add/sub/and/or/slt).
//  The decode stage issues one M-extension op (funct3) with two operands over a valid/ready request channel.
//  One result returns per request on a valid/ready response channel; the core stalls on req_ready/busy.
// PARAMETERS
//  XLEN      32  operand/result width; must be even, >= 8
//  CNT_W      6  iteration counter width; must satisfy 2^CNT_W > XLEN
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     synchronous reset, active low
//  req_valid   in   1     request present
//  req_ready   out  1     unit can accept; high only in IDLE
//  req_op      in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  req_a       in   XLEN  rs1 operand (multiplicand / dividend)
//  req_b       in   XLEN  rs2 operand (multiplier / divisor)
//  rsp_valid   out  1     result valid; held until accepted
//  rsp_ready   in   1     consumer accepts result
//  rsp_result  out  XLEN  result, stable while rsp_valid=1
//  busy        out  1     high in CALC, FIX or DONE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, req_ready=1, rsp_valid=0, rsp_result=0, busy=0, counter=0.
//  Reset dominates every state; an in-flight op is dropped and no response is produced.
//  Request fires on req_valid&req_ready. Op, operand signs and |a|,|b| are captured; inputs may then change.
//  FSM:
//   IDLE -> CALC  on fire, normal case; counter=0.
//   IDLE -> DONE  on fire, special case; result is loaded directly (latency 1).
//   CALC -> FIX   after XLEN iterations.
//   FIX  -> DONE  after 1 cycle; applies sign correction and selects the result half.
//   DONE -> IDLE  on rsp_ready.
//  Multiply: shift-add, 1 bit/cycle over unsigned magnitudes into a 2*XLEN product.
//   Signedness of each operand: MULH s*s, MULHSU s*u, MULHU u*u.
//   MUL returns the low half (sign-independent); MULH* return the high half.
//   Negate the 2*XLEN product when exactly one signed operand is negative.
//  Divide: restoring, 1 quotient bit/cycle over magnitudes.
//   Quotient sign = sign(a)^sign(b); remainder takes the sign of a (signed ops only).
//  Special cases (take the IDLE->DONE path):
//   b==0 on DIV/DIVU: result = all-ones.  b==0 on REM/REMU: result = a.
//   DIV with a=most-negative and b=-1: result = a.  REM, same operands: result = 0.
//  Latency, fire to rsp_valid: XLEN+2 cycles normal, 1 cycle special.
//  Back-to-back: rsp_ready=1 in DONE returns to IDLE; the next fire can occur one cycle later.
//  rsp_valid and rsp_result stay stable while rsp_ready=0. req_valid arriving while busy is ignored (req_ready=0).
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: multiply CALC exits to FIX once the remaining multiplier bits are all zero.
//   Latency becomes 2 + (index of the highest set bit of |b|) + 1; b==0 gives 2 cycles. Results are unchanged.
//  Not defined: fixed XLEN+2 latency for every normal op. Divide is never affected.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - funct3 op localparams (OP_MUL..OP_REMU)
//   - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE)
//   - helper predicates is_div(op), is_signed_a(op), is_signed_b(op)
//  One sub-module, muldiv_cond_neg: parameterised-width conditional two's-complement negate.
//   Used for operand magnitudes and the FIX stage.
//  Datapath: one shared 2*XLEN accumulator/remainder register, one XLEN operand register, one XLEN-wide adder/subtractor.
// TESTING
//  MUL a=7, b=-3 -> 0xFFFFFFEB (-21) after 34 cycles; req_ready low throughout.
//  MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7,2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100,7 -> 2.
//  DIV x/0 -> 0xFFFFFFFF in 1 cycle; REM 5,0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0.
//  Hold rsp_ready=0 for 5 cycles in DONE -> result stable, req_ready=0; then a back-to-back request fires the cycle after acceptance.
//  Drop rst_n mid-CALC -> next edge: IDLE, rsp_valid=0, rsp_result=0; no stale response. With MULDIV_EARLY_OUT_EN: MUL 9*1 -> 9 in 3 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and operand-signedness predicates.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_cond_neg.sv
// Conditional two's-complement negate of a W-bit value.
// Purely combinational; no flow control.
module muldiv_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M mul/div: XLEN+2 cycles normal, 1 cycle for div-by-zero/overflow; req_ready only in IDLE, result held until rsp_ready.
// MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module rv_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            busy
);

    localparam int W2 = 2 * XLEN;

    state_e            state_q;
    logic [2:0]        op_q;
    logic              sa_q, sb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [W2-1:0]     acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   rsp_result_q;
    logic              rsp_valid_q, req_ready_q, busy_q;

    logic              a_neg, b_neg, req_div, b_zero, ovf, special, mul_skip;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res;

    assign a_neg   = is_signed_a(req_op) & req_a[XLEN-1];
    assign b_neg   = is_signed_b(req_op) & req_b[XLEN-1];
    assign req_div = is_div(req_op);
    assign b_zero  = (req_b == '0);
    assign ovf     = req_div && !req_op[0] && (req_b == '1) &&
                     (req_a == {1'b1, {(XLEN-1){1'b0}}});
    assign special = req_div && (b_zero || ovf);
    assign spec_res = b_zero ? (req_op[1] ? req_a : '1)
                             : (req_op[1] ? '0 : req_a);

    muldiv_cond_neg #(.W(XLEN)) u_abs_a (.val(req_a), .neg(a_neg), .res(a_mag));
    muldiv_cond_neg #(.W(XLEN)) u_abs_b (.val(req_b), .neg(b_neg), .res(b_mag));

`ifdef MULDIV_EARLY_OUT_EN
    assign mul_skip = !req_div && (b_mag == '0);
`else
    assign mul_skip = 1'b0;
`endif

    // One shared adder: multiply adds the multiplicand into the upper half,
    // divide trial-subtracts the divisor from the shifted partial remainder.
    logic              div_q;
    logic [XLEN:0]     add_a, add_b, sum;
    logic [W2-1:0]     acc_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              mul_done, calc_exit;

    assign div_q = is_div(op_q);

    always_comb begin
        add_a = {1'b0, acc_q[W2-1:XLEN]};
        add_b = acc_q[0] ? {1'b0, opnd_q} : '0;
        if (div_q) begin
            add_a = acc_q[W2-1:XLEN-1];
            add_b = {1'b0, opnd_q};
        end
    end

    assign sum = add_a + (add_b ^ {(XLEN+1){div_q}}) + {{XLEN{1'b0}}, div_q};

    always_comb begin
        acc_d = {sum, acc_q[XLEN-1:1]};
        if (div_q) begin
            acc_d = sum[XLEN] ? {add_a[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {sum[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
        end
    end

    assign cnt_d = cnt_q + CNT_W'(1);

`ifdef MULDIV_EARLY_OUT_EN
    // Multiplier bits not yet consumed sit in the low XLEN-cnt_d bits.
    assign mul_done = !div_q && ((acc_d[XLEN-1:0] & ({XLEN{1'b1}} >> cnt_d)) == '0);
`else
    assign mul_done = 1'b0;
`endif
    assign calc_exit = (cnt_q == CNT_W'(XLEN - 1)) || mul_done;

    logic [W2-1:0]   fix_src, neg_in, neg_out;
    logic            neg_en;
    logic [XLEN-1:0] res_fix;

`ifdef MULDIV_EARLY_OUT_EN
    // Skipped iterations would only have shifted right; apply them at once.
    assign fix_src = acc_q >> (CNT_W'(XLEN) - cnt_q);
`else
    assign fix_src = acc_q;
`endif

    assign neg_in = div_q ? {{XLEN{1'b0}}, (op_q[1] ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0])}
                          : fix_src;
    assign neg_en = (div_q && op_q[1]) ? sa_q : (sa_q ^ sb_q);

    muldiv_cond_neg #(.W(W2)) u_fix_neg (.val(neg_in), .neg(neg_en), .res(neg_out));

    assign res_fix = (!div_q && (op_q != OP_MUL)) ? neg_out[W2-1:XLEN] : neg_out[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_MUL;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            opnd_q       <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        sa_q        <= a_neg;
                        sb_q        <= b_neg;
                        cnt_q       <= '0;
                        acc_q       <= {{XLEN{1'b0}}, (req_div ? a_mag : b_mag)};
                        opnd_q      <= req_div ? b_mag : a_mag;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (special) begin
                            rsp_result_q <= spec_res;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= mul_skip ? S_FIX : S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                    if (calc_exit) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    rsp_result_q <= res_fix;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = busy_q;

endmodule
